usb_in_ep_buffer: RTL
=====================

Name: usb_in_ep_buffer

Overview:
- Single-packet IN endpoint buffer. It is the far end of the in_ep_* interface that control and bulk endpoint logic writes into.
- Accepts bytes from the application side and commits them as a packet. Answers IN tokens from the protocol engine with DATA, NAK or STALL, streams the bytes out, and tracks the DATA0/DATA1 toggle.
- Reports the host ACK back to the application.

Parameters:
- MAX_PKT, 32, maximum packet size in bytes (power of two, 8..64).
- PTR_W, 6, pointer/length width; must satisfy 2^PTR_W > MAX_PKT.

Ports:
- clk  in  1  endpoint clock.
- reset  in  1  asynchronous, active-high reset.
- in_ep_req  in  1  application requests buffer access.
- in_ep_grant  out  1  access granted.
- in_ep_data_free  out  1  buffer can accept a byte this cycle.
- in_ep_data_put  in  1  write in_ep_data this cycle.
- in_ep_data  in  8  write byte.
- in_ep_data_done  in  1  commit current contents as a packet (may be zero-length).
- in_ep_stall  in  1  pulse: stall endpoint.
- in_ep_acked  out  1  one-cycle pulse: host ACKed the packet.
- in_token  in  1  pulse: IN token addressed to this endpoint.
- setup_token  in  1  pulse: SETUP token addressed to this endpoint.
- tx_rsp_valid  out  1  one-cycle pulse: response decision.
- tx_rsp  out  2  0 = NAK, 1 = DATA, 2 = STALL.
- tx_data_toggle  out  1  0 = DATA0, 1 = DATA1 PID for the current packet.
- tx_data_avail  out  1  more bytes remain to transmit.
- tx_data_get  in  1  consume tx_data this cycle.
- tx_data  out  8  byte at the read pointer (combinational from the buffer).
- host_ack  in  1  pulse: ACK handshake received.
- host_timeout  in  1  pulse: no handshake within turnaround.

Behaviour:
- Reset (async, active-high):
  - state = FILL; wr_ptr = rd_ptr = pkt_len = 0; toggle = 0; stall latch = 0.
  - All outputs 0.
- State FILL:
  - in_ep_grant = in_ep_req.
  - in_ep_data_free = (wr_ptr < MAX_PKT).
  - put with free: mem[wr_ptr] <= data; wr_ptr++.
  - put when wr_ptr == MAX_PKT: ignored, no wrap.
  - data_done: pkt_len <= wr_ptr (plus 1 if a valid put occurs in the same cycle); go READY next cycle.
  - Reaching wr_ptr == MAX_PKT does not auto-commit; data_done is required.
- State READY:
  - in_ep_data_free = 0; grant = 0.
  - in_token: rd_ptr <= 0; go XMIT.
- State XMIT:
  - tx_data_avail = (rd_ptr < pkt_len).
  - tx_data_get: rd_ptr++.
  - get while avail = 0: ignored.
  - When rd_ptr == pkt_len (immediately if pkt_len = 0): go WAIT_ACK.
- State WAIT_ACK:
  - host_ack: toggle flips; in_ep_acked pulses the cycle after; wr_ptr = pkt_len = 0; go FILL.
  - host_timeout: go READY with the same data and same toggle (retransmit).
  - host_ack and host_timeout in the same cycle: host_ack wins.
- Token response:
  - tx_rsp_valid pulses exactly 1 cycle after in_token.
  - Priority: stall latch set → STALL (no state change); else state READY → DATA; else NAK.
  - in_token in XMIT or WAIT_ACK → NAK, no state change.
- Stall:
  - in_ep_stall sets the latch from any state.
  - Packet contents are kept, but no DATA response is given while the latch is set.
- setup_token (any state):
  - Clears the stall latch; sets toggle = 1 (first IN after SETUP uses DATA1).
  - Flushes the buffer: wr_ptr = rd_ptr = pkt_len = 0; state = FILL.
  - Same-cycle conflicts: setup_token overrides in_ep_stall, data_done, put and host_ack.
- Width rules: pointers are PTR_W bits; comparisons are unsigned; no arithmetic wraps.

Test Plan:
- Put 0x12, 0x34, 0x56, then data_done; in_token → tx_rsp = 1 one cycle later, toggle = 0. Three gets yield 12, 34, 56, then avail = 0. host_ack → in_ep_acked pulse; toggle becomes 1; data_free = 1 again.
- in_token while FILL with 2 bytes → tx_rsp = 0 (NAK). Then data_done + in_token → DATA with 2 bytes.
- Full packet: 32 puts, 33rd put ignored, data_done → pkt_len = 32. host_timeout after transmit → next in_token resends the same 32 bytes with the same toggle.
- data_done with no bytes, then in_token → DATA, tx_data_avail = 0 immediately. host_ack → toggle flips.
- in_ep_stall, then in_token → tx_rsp = 2 (repeated on every token). setup_token → next in_token NAKs, toggle = 1.
- Assert reset asynchronously mid-XMIT → all outputs 0 without a clock edge. After release, in_token → NAK.

Source files
------------

// File: rtl/usb_in_ep_buffer.sv
// Single-packet IN endpoint buffer.
// The application fills the buffer and commits it as one packet. The buffer
// answers IN tokens with DATA/NAK/STALL, streams the bytes out and keeps the
// DATA0/DATA1 toggle. Host ACK frees the buffer and is reported back.
//
//   state    | meaning
//   FILL     | application may write bytes; waiting for data_done
//   READY    | packet committed; next IN token starts transmission
//   XMIT     | streaming bytes to the protocol engine
//   WAIT_ACK | packet sent; waiting for host handshake or timeout
module usb_in_ep_buffer #(
    parameter int MAX_PKT = 32,
    parameter int PTR_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_ep_req,
    output logic       in_ep_grant,
    output logic       in_ep_data_free,
    input  logic       in_ep_data_put,
    input  logic [7:0] in_ep_data,
    input  logic       in_ep_data_done,
    input  logic       in_ep_stall,
    output logic       in_ep_acked,
    input  logic       in_token,
    input  logic       setup_token,
    output logic       tx_rsp_valid,
    output logic [1:0] tx_rsp,
    output logic       tx_data_toggle,
    output logic       tx_data_avail,
    input  logic       tx_data_get,
    output logic [7:0] tx_data,
    input  logic       host_ack,
    input  logic       host_timeout
);

    localparam int              AW      = $clog2(MAX_PKT);
    localparam logic [PTR_W-1:0] MAX_LEN = PTR_W'(MAX_PKT);

    localparam logic [1:0] RSP_NAK   = 2'd0;
    localparam logic [1:0] RSP_DATA  = 2'd1;
    localparam logic [1:0] RSP_STALL = 2'd2;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        READY    = 2'd1,
        XMIT     = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] pkt_len_q, pkt_len_d;
    logic             toggle_q, toggle_d;
    logic             stall_q, stall_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [1:0]       rsp_q, rsp_d;
    logic             acked_q, acked_d;

    logic [7:0]       mem_q [MAX_PKT];

    logic             put_ok;
    logic             get_ok;

    assign put_ok = (state_q == FILL) && in_ep_data_put && (wr_ptr_q < MAX_LEN);
    assign get_ok = (state_q == XMIT) && tx_data_get && (rd_ptr_q < pkt_len_q);

    // Next-state logic for the FSM, pointers, toggle, stall latch and pulses.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_len_d   = pkt_len_q;
        toggle_d    = toggle_q;
        stall_d     = stall_q;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        acked_d     = 1'b0;

        // Token decision uses the state as it was when the token arrived.
        if (in_token) begin
            rsp_valid_d = 1'b1;
            if (stall_q)
                rsp_d = RSP_STALL;
            else if (state_q == READY)
                rsp_d = RSP_DATA;
            else
                rsp_d = RSP_NAK;
        end

        if (in_ep_stall)
            stall_d = 1'b1;

        case (state_q)
            FILL: begin
                if (put_ok)
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (in_ep_data_done) begin
                    pkt_len_d = wr_ptr_q + (put_ok ? PTR_W'(1) : PTR_W'(0));
                    state_d   = READY;
                end
            end
            READY: begin
                // A stalled endpoint keeps its packet parked here.
                if (in_token && !stall_q) begin
                    rd_ptr_d = '0;
                    state_d  = XMIT;
                end
            end
            XMIT: begin
                if (get_ok)
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                if (rd_ptr_q == pkt_len_q)
                    state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (host_ack) begin
                    toggle_d  = ~toggle_q;
                    acked_d   = 1'b1;
                    wr_ptr_d  = '0;
                    pkt_len_d = '0;
                    state_d   = FILL;
                end else if (host_timeout) begin
                    state_d = READY;
                end
            end
            default: state_d = FILL;
        endcase

        // SETUP restarts the control transfer and beats every other event.
        if (setup_token) begin
            stall_d   = 1'b0;
            toggle_d  = 1'b1;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pkt_len_d = '0;
            acked_d   = 1'b0;
            state_d   = FILL;
        end
    end

    // FSM and control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_len_q   <= '0;
            toggle_q    <= 1'b0;
            stall_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= RSP_NAK;
            acked_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_len_q   <= pkt_len_d;
            toggle_q    <= toggle_d;
            stall_q     <= stall_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
            acked_q     <= acked_d;
        end
    end

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (put_ok && !setup_token)
            mem_q[wr_ptr_q[AW-1:0]] <= in_ep_data;
    end

    // Combinational outputs are forced low while reset is held so the
    // interface goes quiet immediately, without waiting for a clock edge.
    assign in_ep_grant     = !reset && (state_q == FILL) && in_ep_req;
    assign in_ep_data_free = !reset && (state_q == FILL) && (wr_ptr_q < MAX_LEN);
    assign tx_data_avail   = !reset && (state_q == XMIT) && (rd_ptr_q < pkt_len_q);
    assign tx_data         = reset ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign tx_data_toggle  = toggle_q;
    assign tx_rsp_valid    = rsp_valid_q;
    assign tx_rsp          = rsp_q;
    assign in_ep_acked     = acked_q;

endmodule
